gps_corr_dump_collector: RTL and testbench

Multi-channel collector for correlator dump results. Captures Early/Prompt/Late I/Q accumulations from NUM_CH correlator channels on each channel's dump pulse and computes E/P/L powers (I^2+Q^2) in hardware. Applies a prompt-power detection threshold and serialises results onto one valid/ready stream toward the tracking-loop processor. Generalises single-channel dump handling to N channels with buffering, round-robin arbitration, backpressure and overrun reporting.

---
 rtl/gps_corr_dump_collector_if.sv | 20 ++
 rtl/gps_corr_dump_collector.sv | 129 ++++++++++++
 tb/tb_gps_corr_dump_collector.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gps_corr_dump_collector_if.sv
// gps_corr_dump_collector_if: valid/ready result stream toward the tracking-loop processor
interface gps_corr_dump_collector_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 18,
  parameter int SEQ_W = 16,
  parameter int POW_W = 2*ACC_W
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic out_valid;
  logic out_ready;
  logic [CW-1:0] out_ch;
  logic [SEQ_W-1:0] out_seq;
  logic [6*ACC_W-1:0] out_acc;
  logic [POW_W-1:0] out_pe;
  logic [POW_W-1:0] out_pp;
  logic [POW_W-1:0] out_pl;
  logic out_det;
  modport master (output out_valid, out_ch, out_seq, out_acc, out_pe, out_pp, out_pl, out_det, input out_ready);
  modport slave (input out_valid, out_ch, out_seq, out_acc, out_pe, out_pp, out_pl, out_det, output out_ready);
endinterface

// File: rtl/gps_corr_dump_collector.sv
// gps_corr_dump_collector: captures per-channel E/P/L dumps, squares them and serialises powers round-robin
module gps_corr_dump_collector #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 18,
  parameter int SEQ_W = 16,
  parameter int POW_W = 2*ACC_W
) (
  input  logic clk,
  input  logic rstn,
  input  logic [NUM_CH-1:0] ch_dump,
  input  logic [NUM_CH*6*ACC_W-1:0] ch_acc,
  input  logic [POW_W-1:0] det_thresh,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] ovf_flags,
  output logic busy,
  gps_corr_dump_collector_if.master ob
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = 6*ACC_W;
  localparam int SW = 2*ACC_W-1;
  logic [AW-1:0] hold [NUM_CH];
  logic [SEQ_W-1:0] seq [NUM_CH];
  logic [SEQ_W-1:0] seq_hold [NUM_CH];
  logic [NUM_CH-1:0] pend, gmask;
  logic [CW-1:0] last_grant, grant;
  logic grant_v, adv;
  logic [AW-1:0] g;
  logic signed [ACC_W-1:0] v;
  logic signed [2*ACC_W-1:0] ve, p;
  logic [SW-1:0] sq [6];
  logic [POW_W-1:0] pp_sum;
  logic s1_v, s1_det;
  logic [CW-1:0] s1_ch;
  logic [SEQ_W-1:0] s1_seq;
  logic [AW-1:0] s1_acc;
  logic [SW-1:0] s1_sq [6];
  assign adv = !ob.out_valid | ob.out_ready;
  assign busy = |pend | s1_v | ob.out_valid;
  // descending scan so the nearest pending channel after last_grant wins
  always_comb begin
    grant = '0;
    grant_v = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (pend[CW'((int'(last_grant) + i) % NUM_CH)]) begin
        grant = CW'((int'(last_grant) + i) % NUM_CH);
        grant_v = adv;
      end
    end
    gmask = grant_v ? NUM_CH'(1) << grant : '0;
  end
  always_comb begin
    g = hold[grant];
    v = '0;
    ve = '0;
    p = '0;
    for (int j = 0; j < 6; j++) begin
      v = signed'(g[j*ACC_W +: ACC_W]);
      ve = (2*ACC_W)'(v);
      p = ve * ve;
      sq[j] = p[SW-1:0];
    end
    pp_sum = POW_W'(sq[2]) + POW_W'(sq[3]);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
      ovf_flags <= '0;
      last_grant <= CW'(NUM_CH-1);
      for (int k = 0; k < NUM_CH; k++) begin
        hold[k] <= '0;
        seq[k] <= '0;
        seq_hold[k] <= '0;
      end
    end else begin
      pend <= (pend & ~gmask) | ch_dump;
      ovf_flags <= (ovf_flags & ~ovf_clr) | (ch_dump & pend & ~gmask);
      if (grant_v) last_grant <= grant;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_dump[k]) begin
          hold[k] <= ch_acc[k*AW +: AW];
          seq_hold[k] <= seq[k];
          seq[k] <= seq[k] + SEQ_W'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s1_det <= 1'b0;
      s1_ch <= '0;
      s1_seq <= '0;
      s1_acc <= '0;
      for (int j = 0; j < 6; j++) s1_sq[j] <= '0;
    end else if (adv) begin
      s1_v <= grant_v;
      if (grant_v) begin
        s1_det <= pp_sum >= det_thresh;
        s1_ch <= grant;
        s1_seq <= seq_hold[grant];
        s1_acc <= g;
        for (int j = 0; j < 6; j++) s1_sq[j] <= sq[j];
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ob.out_valid <= 1'b0;
      ob.out_ch <= '0;
      ob.out_seq <= '0;
      ob.out_acc <= '0;
      ob.out_pe <= '0;
      ob.out_pp <= '0;
      ob.out_pl <= '0;
      ob.out_det <= 1'b0;
    end else if (adv) begin
      ob.out_valid <= s1_v;
      if (s1_v) begin
        ob.out_ch <= s1_ch;
        ob.out_seq <= s1_seq;
        ob.out_acc <= s1_acc;
        ob.out_pe <= POW_W'(s1_sq[0]) + POW_W'(s1_sq[1]);
        ob.out_pp <= POW_W'(s1_sq[2]) + POW_W'(s1_sq[3]);
        ob.out_pl <= POW_W'(s1_sq[4]) + POW_W'(s1_sq[5]);
        ob.out_det <= s1_det;
      end
    end
  end
endmodule

// File: tb/tb_gps_corr_dump_collector.sv
// tb_gps_corr_dump_collector: directed stimulus with a queued-expectation monitor
module tb_gps_corr_dump_collector;
  localparam int N = 4;
  localparam int A = 18;
  localparam int P = 36;
  typedef struct {
    int ch;
    logic [15:0] seq;
    logic [6*A-1:0] acc;
    logic [P-1:0] pe, pp, pl;
    logic det;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] ch_dump = '0;
  logic [N*6*A-1:0] ch_acc = '0;
  logic [P-1:0] det_thresh = '0;
  logic [N-1:0] ovf_clr = '0;
  logic [N-1:0] ovf_flags;
  logic busy;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  int accv [N][6];
  int lv [N][6];
  logic [6*A-1:0] lacc [N];
  logic [15:0] seqm [N];
  logic [15:0] lseq [N];
  gps_corr_dump_collector_if #(.NUM_CH(N), .ACC_W(A), .SEQ_W(16)) ob ();
  gps_corr_dump_collector #(.NUM_CH(N), .ACC_W(A), .SEQ_W(16)) dut (
    .clk(clk), .rstn(rstn), .ch_dump(ch_dump), .ch_acc(ch_acc), .det_thresh(det_thresh),
    .ovf_clr(ovf_clr), .ovf_flags(ovf_flags), .busy(busy), .ob(ob)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rstn && ob.out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        chk("out_ch", 128'(ob.out_ch), 128'(q[0].ch));
        chk("out_seq", 128'(ob.out_seq), 128'(q[0].seq));
        chk("out_acc", 128'(ob.out_acc), 128'(q[0].acc));
        chk("out_pe", 128'(ob.out_pe), 128'(q[0].pe));
        chk("out_pp", 128'(ob.out_pp), 128'(q[0].pp));
        chk("out_pl", 128'(ob.out_pl), 128'(q[0].pl));
        chk("out_det", 128'(ob.out_det), 128'(q[0].det));
        if (ob.out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic dump(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 6; j++) ch_acc[(k*6+j)*A +: A] = A'(accv[k][j]);
      if (m[k]) begin
        lseq[k] = seqm[k];
        seqm[k] = seqm[k] + 16'd1;
        for (int j = 0; j < 6; j++) begin
          lacc[k][j*A +: A] = A'(accv[k][j]);
          lv[k][j] = accv[k][j];
        end
      end
    end
    ch_dump = m;
    tick();
    ch_dump = '0;
  endtask
  task automatic push_exp(input int ch);
    exp_t e;
    longint s [6];
    for (int j = 0; j < 6; j++) s[j] = longint'(lv[ch][j]) * longint'(lv[ch][j]);
    e.ch = ch;
    e.seq = lseq[ch];
    e.acc = lacc[ch];
    e.pe = P'(s[0] + s[1]);
    e.pp = P'(s[2] + s[3]);
    e.pl = P'(s[4] + s[5]);
    e.det = e.pp >= det_thresh;
    q.push_back(e);
  endtask
  task automatic push_hand(input int ch, input logic [P-1:0] pe, input logic [P-1:0] pp, input logic [P-1:0] pl, input logic det);
    exp_t e;
    e.ch = ch;
    e.seq = lseq[ch];
    e.acc = lacc[ch];
    e.pe = pe;
    e.pp = pp;
    e.pl = pl;
    e.det = det;
    q.push_back(e);
  endtask
  task automatic set_acc(input int k, input int ie, input int qe, input int ip, input int qp, input int il, input int ql);
    accv[k][0] = ie; accv[k][1] = qe; accv[k][2] = ip;
    accv[k][3] = qp; accv[k][4] = il; accv[k][5] = ql;
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !busy && q.size() == 0;
    end
    chk("drain_idle", 128'(done), 1);
  endtask
  task automatic latency(input string n);
    @(negedge clk);
    chk({n, "_lat1"}, 128'(ob.out_valid), 0);
    @(negedge clk);
    chk({n, "_lat2"}, 128'(ob.out_valid), 0);
    @(negedge clk);
    chk({n, "_lat3"}, 128'(ob.out_valid), 1);
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    for (int k = 0; k < N; k++) seqm[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < N; k++) begin
      seqm[k] = '0;
      set_acc(k, 0, 0, 0, 0, 0, 0);
    end
    ob.out_ready = 1'b1;
    #12;
    chk("rst_valid", 128'(ob.out_valid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_ovf", 128'(ovf_flags), 0);
    chk("rst_pp", 128'(ob.out_pp), 0);
    do_reset();
    // single dump on ch2, both threshold sides
    det_thresh = 36'd25000000;
    set_acc(2, 100, -50, 3000, -4000, 7, 0);
    dump(4'b0100);
    push_hand(2, 36'd12500, 36'd25000000, 36'd49, 1'b1);
    latency("single");
    wait_idle();
    det_thresh = 36'd25000001;
    dump(4'b0100);
    push_hand(2, 36'd12500, 36'd25000000, 36'd49, 1'b0);
    wait_idle();
    // all channels at once, then RR resumes from ch3
    do_reset();
    det_thresh = 36'd1000;
    set_acc(0, 1, 2, 3, 4, 5, 6);
    set_acc(1, -10, 20, -30, 40, -50, 60);
    set_acc(2, 131071, -131071, 0, 31, -1, 1);
    set_acc(3, 7, 7, 22, 22, -9, 100);
    dump(4'b1111);
    for (int k = 0; k < N; k++) push_exp(k);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_valid", 128'(ob.out_valid), 1);
    end
    wait_idle();
    dump(4'b0011);
    push_exp(0);
    push_exp(1);
    wait_idle();
    // stall with ch1 overrun
    do_reset();
    ob.out_ready = 1'b0;
    set_acc(0, 11, 12, 13, 14, 15, 16);
    set_acc(2, -1, -2, -3, -4, -5, -6);
    dump(4'b0101);
    push_exp(0);
    push_exp(2);
    repeat (3) tick();
    set_acc(1, 500, 600, 700, 800, 900, 1000);
    dump(4'b0010);
    repeat (9) tick();
    set_acc(1, -1000, 2000, 40000, -30000, 5, -5);
    dump(4'b0010);
    push_exp(1);
    repeat (3) tick();
    @(negedge clk);
    chk("stall_ovf", 128'(ovf_flags), 4'b0010);
    chk("stall_busy", 128'(busy), 1);
    chk("stall_valid", 128'(ob.out_valid), 1);
    tick();
    ob.out_ready = 1'b1;
    wait_idle();
    chk("ovf_sticky", 128'(ovf_flags), 4'b0010);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    @(negedge clk);
    chk("ovf_cleared", 128'(ovf_flags), 0);
    // most negative inputs give exactly 2^35
    det_thresh = 36'h8_0000_0000;
    set_acc(3, -131072, -131072, -131072, -131072, -131072, -131072);
    dump(4'b1000);
    push_hand(3, 36'h8_0000_0000, 36'h8_0000_0000, 36'h8_0000_0000, 1'b1);
    wait_idle();
    // dump on ch0 in the cycle it is granted
    set_acc(0, 1, 1, 1, 1, 1, 1);
    dump(4'b0001);
    push_exp(0);
    set_acc(0, 2, 3, 4, 5, 6, 7);
    dump(4'b0001);
    push_exp(0);
    wait_idle();
    chk("grant_dump_ovf", 128'(ovf_flags), 0);
    // reset with results buffered and output stalled
    ob.out_ready = 1'b0;
    set_acc(1, 9, 9, 9, 9, 9, 9);
    dump(4'b0111);
    push_exp(1);
    push_exp(2);
    push_exp(0);
    repeat (5) tick();
    @(negedge clk);
    chk("pre_rst_valid", 128'(ob.out_valid), 1);
    chk("pre_rst_busy", 128'(busy), 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(ob.out_valid), 0);
    chk("mid_rst_busy", 128'(busy), 0);
    q.delete();
    for (int k = 0; k < N; k++) seqm[k] = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    ob.out_ready = 1'b1;
    set_acc(3, -77, 88, 1234, -4321, 0, -131071);
    dump(4'b1000);
    push_exp(3);
    latency("post_rst");
    wait_idle();
    chk("queue_empty", 128'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
